decode_issue_stage: RTL and testbench
=====================================

// Module: decode_issue_stage
// PURPOSE
//  Registered RV32I decode stage between InstQueue and dispatch/regfile; successor to the combinational decoder.
//  Adds valid/ready handshakes on both sides, ROB tag allocation with wrap-around and in-flight occupancy tracking,
//  flush support, and an illegal-instruction flag. Parametrised in data/tag width and ROB depth.
// PARAMETERS
//  XLEN       32  data/address width
//  TAG_WIDTH   4  width of out_tag; must satisfy 2**TAG_WIDTH >= ROB_DEPTH
//  ROB_DEPTH  16  number of allocatable tags (0..ROB_DEPTH-1)
//  OP_WIDTH    6  width of out_op
// PORTS
//  clk           in   1          clock, rising edge
//  rst           in   1          reset, synchronous, active-high
//  rdy           in   1          global enable; 0 freezes all state
//  flush         in   1          mispredict flush; drops output and tag state
//  iq_valid      in   1          InstQueue has an instruction
//  iq_inst       in   32         instruction word
//  iq_pc         in   XLEN       instruction PC
//  iq_ready      out  1          stage accepts iq_inst this cycle (combinational)
//  commit_valid  in   1          ROB retired one entry; frees one tag
//  out_ready     in   1          dispatch accepts the output register
//  out_valid     out  1          output register holds a decoded instruction
//  out_op        out  OP_WIDTH   op code (encoding below)
//  out_rs1/2     out  5 each     source register indices
//  out_rs1_valid out  1          rs1 is read
//  out_rs2_valid out  1          rs2 is read
//  out_rd        out  5          destination index
//  out_rd_valid  out  1          writes rd; forced 0 when rd==x0
//  out_imm       out  XLEN       sign-/zero-extended immediate
//  out_pc        out  XLEN       PC of decoded instruction
//  out_tag       out  TAG_WIDTH  allocated ROB tag
//  out_illegal   out  1          unsupported encoding
// BEHAVIOUR
//  - Op codes: 0 NOP/illegal; LUI 1, AUIPC 2, JAL 3, JALR 4; BEQ,BNE,BLT,BGE,BLTU,BGEU 5-10; LB,LH,LW,LBU,LHU 11-15;
//    SB,SH,SW 16-18; ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI 19-27; ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND 28-37.
//  - Immediates per RV32I I/S/B/U/J formats, sign-extended to XLEN; SLLI/SRLI/SRAI imm = zero-extended inst[24:20].
//  - Unused rs*/rd fields are driven 0 with their valid bits 0. LUI/AUIPC/JAL read no sources.
//  - Illegal = unknown opcode, funct3, or funct7 (R-type and shifts). The instruction is accepted and consumes a tag,
//    with out_illegal=1, op=0, all valid bits 0.
//  - Occupancy count in 0..ROB_DEPTH; rob_full = (count == ROB_DEPTH).
//  - iq_ready = rdy & ~rst & ~flush & ~rob_full & (~out_valid | out_ready).
//  - Accept = iq_valid & iq_ready: output register loads next cycle with the decoded fields,
//    out_tag = next_tag, next_tag += 1 (wraps ROB_DEPTH-1 -> 0), count += 1. Latency is 1 cycle.
//  - Output register states are EMPTY and FULL.
//    EMPTY -> FULL on accept.
//    FULL -> EMPTY when out_ready & ~accept.
//    FULL -> FULL on simultaneous pop and accept (back-to-back, no bubble).
//    While FULL & ~out_ready, all out_* fields hold stable.
//  - commit_valid decrements count (saturates at 0). Accept and commit in the same cycle leave count unchanged.
//  - Flush (rdy=1) has priority over accept and commit: out_valid=0, next_tag=0, count=0.
//  - rdy=0: no state changes, iq_ready=0, outputs hold.
//  - Reset (also mid-operation): all out_* = 0, next_tag = 0, count = 0, iq_ready = 0 during reset.
// TESTING
//  1. Assert rst for 2 cycles with iq_valid=1 -> out_valid=0, all outputs 0, nothing accepted; first accept after release gets tag 0.
//  2. iq_inst=0xFFF00093 (addi x1,x0,-1), pc=0x100 -> next cycle out_valid=1, op=19, imm=0xFFFFFFFF, rs1=0 (valid), rd=1, pc=0x100, tag=0.
//  3. FULL with out_ready=0 for 3 cycles -> iq_ready=0, outputs stable. Then out_ready=1 with iq_valid=1 -> new instruction loaded with no bubble, tag=1.
//  4. ROB_DEPTH=4, 4 accepts with no commit -> tags 0,1,2,3, then iq_ready=0. Pulse commit_valid -> next accept gets tag 0 (wrap).
//  5. flush in the same cycle as iq_valid=1 while FULL -> iq_ready=0, next cycle out_valid=0; next accept gets tag 0.
//  6. iq_inst=0xFFFFFFFF -> out_illegal=1, op=0, valid bits 0, tag consumed. Then 0x40B50533 (sub x10,x10,x11) -> op=29, illegal=0.

Source files
------------

// File: rtl/decode_issue_if.sv
// Handshake bundle between InstQueue, the decode/issue stage and dispatch.
// master is the decode stage side; slave is the queue/dispatch environment.
interface decode_issue_if #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 4,
  parameter int OP_WIDTH  = 6
) ();
  logic                 iq_valid;
  logic [31:0]          iq_inst;
  logic [XLEN-1:0]      iq_pc;
  logic                 iq_ready;
  logic                 out_ready;
  logic                 out_valid;
  logic [OP_WIDTH-1:0]  out_op;
  logic [4:0]           out_rs1;
  logic [4:0]           out_rs2;
  logic                 out_rs1_valid;
  logic                 out_rs2_valid;
  logic [4:0]           out_rd;
  logic                 out_rd_valid;
  logic [XLEN-1:0]      out_imm;
  logic [XLEN-1:0]      out_pc;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 out_illegal;

  modport master (
    input  iq_valid, iq_inst, iq_pc, out_ready,
    output iq_ready, out_valid, out_op, out_rs1, out_rs2, out_rs1_valid, out_rs2_valid,
           out_rd, out_rd_valid, out_imm, out_pc, out_tag, out_illegal
  );

  modport slave (
    output iq_valid, iq_inst, iq_pc, out_ready,
    input  iq_ready, out_valid, out_op, out_rs1, out_rs2, out_rs1_valid, out_rs2_valid,
           out_rd, out_rd_valid, out_imm, out_pc, out_tag, out_illegal
  );
endinterface

// File: rtl/decode_issue_stage.sv
// Registered RV32I decode stage: decodes one instruction per accept into an output
// register and hands out ROB tags, tracking how many are in flight.
module decode_issue_stage #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 4,
  parameter int ROB_DEPTH = 16,
  parameter int OP_WIDTH  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            commit_valid,
  decode_issue_if.master  io
);
  localparam int CNT_W = $clog2(ROB_DEPTH + 1);

  typedef enum logic [0:0] {EMPTY, FULL} state_t;

  state_t               state;
  logic [TAG_WIDTH-1:0] next_tag;
  logic [CNT_W-1:0]     count;
  logic                 rob_full;
  logic                 accept;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm32;
  int          op_num;
  logic        use_rs1, use_rs2, use_rd, dec_illegal;

  assign inst   = io.iq_inst;
  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = {27'b0, inst[24:20]};

  assign rob_full     = (count == CNT_W'(ROB_DEPTH));
  assign io.iq_ready  = rdy & ~rst & ~flush & ~rob_full & ((state == EMPTY) | io.out_ready);
  assign accept       = io.iq_valid & io.iq_ready;
  assign io.out_valid = (state == FULL);

  always_comb begin
    op_num      = 0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    use_rd      = 1'b0;
    imm32       = '0;
    dec_illegal = 1'b0;
    case (opcode)
      7'b0110111: begin op_num = 1; use_rd = 1'b1; imm32 = imm_u; end
      7'b0010111: begin op_num = 2; use_rd = 1'b1; imm32 = imm_u; end
      7'b1101111: begin op_num = 3; use_rd = 1'b1; imm32 = imm_j; end
      7'b1100111: begin
        op_num = 4; use_rs1 = 1'b1; use_rd = 1'b1; imm32 = imm_i;
        dec_illegal = (f3 != 3'd0);
      end
      7'b1100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm32 = imm_b;
        case (f3)
          3'd0: op_num = 5;   3'd1: op_num = 6;   3'd4: op_num = 7;
          3'd5: op_num = 8;   3'd6: op_num = 9;   3'd7: op_num = 10;
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b0000011: begin
        use_rs1 = 1'b1; use_rd = 1'b1; imm32 = imm_i;
        case (f3)
          3'd0: op_num = 11;  3'd1: op_num = 12;  3'd2: op_num = 13;
          3'd4: op_num = 14;  3'd5: op_num = 15;
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b0100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm32 = imm_s;
        case (f3)
          3'd0: op_num = 16;  3'd1: op_num = 17;  3'd2: op_num = 18;
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b0010011: begin
        use_rs1 = 1'b1; use_rd = 1'b1; imm32 = imm_i;
        case (f3)
          3'd0: op_num = 19;  3'd2: op_num = 20;  3'd3: op_num = 21;
          3'd4: op_num = 22;  3'd6: op_num = 23;  3'd7: op_num = 24;
          3'd1: begin
            imm32 = imm_sh; op_num = 25;
            dec_illegal = (f7 != 7'b0000000);
          end
          default: begin
            imm32 = imm_sh;
            if (f7 == 7'b0000000)      op_num = 26;
            else if (f7 == 7'b0100000) op_num = 27;
            else                       dec_illegal = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'd0: op_num = 28;  3'd1: op_num = 30;  3'd2: op_num = 31;  3'd3: op_num = 32;
            3'd4: op_num = 33;  3'd5: op_num = 34;  3'd6: op_num = 36;  default: op_num = 37;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'd0) op_num = 29;
        else if (f7 == 7'b0100000 && f3 == 3'd5)     op_num = 35;
        else                                         dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Illegal encodings still travel down the pipe, but as an inert NOP.
    if (dec_illegal) begin
      op_num  = 0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      imm32   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= EMPTY;
      next_tag         <= '0;
      count            <= '0;
      io.out_op        <= '0;
      io.out_rs1       <= '0;
      io.out_rs2       <= '0;
      io.out_rs1_valid <= 1'b0;
      io.out_rs2_valid <= 1'b0;
      io.out_rd        <= '0;
      io.out_rd_valid  <= 1'b0;
      io.out_imm       <= '0;
      io.out_pc        <= '0;
      io.out_tag       <= '0;
      io.out_illegal   <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        state    <= EMPTY;
        next_tag <= '0;
        count    <= '0;
      end else begin
        if (accept) begin
          state            <= FULL;
          io.out_op        <= OP_WIDTH'(op_num);
          io.out_rs1       <= use_rs1 ? inst[19:15] : 5'd0;
          io.out_rs2       <= use_rs2 ? inst[24:20] : 5'd0;
          io.out_rs1_valid <= use_rs1;
          io.out_rs2_valid <= use_rs2;
          io.out_rd        <= use_rd ? inst[11:7] : 5'd0;
          io.out_rd_valid  <= use_rd & (inst[11:7] != 5'd0);
          io.out_imm       <= XLEN'($signed(imm32));
          io.out_pc        <= io.iq_pc;
          io.out_tag       <= next_tag;
          io.out_illegal   <= dec_illegal;
          next_tag         <= (next_tag == TAG_WIDTH'(ROB_DEPTH - 1)) ? '0 : next_tag + 1'b1;
        end else if (io.out_ready) begin
          state <= EMPTY;
        end
        if (accept && !commit_valid)                 count <= count + 1'b1;
        else if (!accept && commit_valid && count != '0) count <= count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage with a 4-entry ROB so tag wrap and
// ROB-full stalls are reached quickly.
module tb_decode_issue_stage;
  logic clk = 1'b0;
  logic rst, rdy, flush, commit_valid;
  int   total = 0;
  int   fails = 0;

  decode_issue_if #(.XLEN(32), .TAG_WIDTH(4), .OP_WIDTH(6)) bus ();

  decode_issue_stage #(.XLEN(32), .TAG_WIDTH(4), .ROB_DEPTH(4), .OP_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .commit_valid(commit_valid), .io(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                input logic ordy, input logic cmt, input logic fl);
    bus.iq_valid  = v;
    bus.iq_inst   = inst;
    bus.iq_pc     = pc;
    bus.out_ready = ordy;
    commit_valid  = cmt;
    flush         = fl;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  logic [31:0] t4_inst [4] = '{32'h00000013, 32'h123452B7, 32'h0020A423, 32'hFE000EE3};
  logic [31:0] t4_op   [4] = '{32'd19, 32'd1, 32'd18, 32'd5};
  logic [31:0] t4_imm  [4] = '{32'h0, 32'h12345000, 32'h8, 32'hFFFFFFFC};
  logic        t4_rdv  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic        t4_rs1v [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    apply_stimulus(1'b1, 32'hFFF00093, 32'h100, 1'b0, 1'b0, 1'b0);
    #1 check_output("rst_iq_ready", bus.iq_ready, 0);
    tick();
    tick();
    check_output("rst_out_valid", bus.out_valid, 0);
    check_output("rst_out_op", bus.out_op, 0);
    check_output("rst_out_imm", bus.out_imm, 0);
    check_output("rst_out_pc", bus.out_pc, 0);
    check_output("rst_out_tag", bus.out_tag, 0);
    check_output("rst_out_rd", bus.out_rd, 0);

    rst = 1'b0;
    #1 check_output("rel_iq_ready", bus.iq_ready, 1);
    tick();
    check_output("addi_valid", bus.out_valid, 1);
    check_output("addi_op", bus.out_op, 19);
    check_output("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    check_output("addi_rs1", bus.out_rs1, 0);
    check_output("addi_rs1_valid", bus.out_rs1_valid, 1);
    check_output("addi_rs2_valid", bus.out_rs2_valid, 0);
    check_output("addi_rd", bus.out_rd, 1);
    check_output("addi_rd_valid", bus.out_rd_valid, 1);
    check_output("addi_pc", bus.out_pc, 32'h100);
    check_output("addi_tag", bus.out_tag, 0);

    // Output stalled by dispatch: nothing moves for three cycles.
    apply_stimulus(1'b1, 32'h002081B3, 32'h104, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check_output("stall_iq_ready", bus.iq_ready, 0);
      tick();
      check_output("stall_pc", bus.out_pc, 32'h100);
      check_output("stall_op", bus.out_op, 19);
    end
    bus.out_ready = 1'b1;
    #1 check_output("pop_iq_ready", bus.iq_ready, 1);
    tick();
    check_output("add_valid", bus.out_valid, 1);
    check_output("add_op", bus.out_op, 28);
    check_output("add_tag", bus.out_tag, 1);
    check_output("add_rs1", bus.out_rs1, 1);
    check_output("add_rs2", bus.out_rs2, 2);
    check_output("add_rs2_valid", bus.out_rs2_valid, 1);
    check_output("add_rd", bus.out_rd, 3);
    check_output("add_pc", bus.out_pc, 32'h104);

    apply_stimulus(1'b1, 32'h00000013, 32'h108, 1'b1, 1'b0, 1'b1);
    #1 check_output("flush_iq_ready", bus.iq_ready, 0);
    tick();
    check_output("flush_out_valid", bus.out_valid, 0);

    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, t4_inst[i], 32'h200 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      tick();
      check_output($sformatf("fill%0d_tag", i), bus.out_tag, 32'(i));
      check_output($sformatf("fill%0d_op", i), bus.out_op, t4_op[i]);
      check_output($sformatf("fill%0d_imm", i), bus.out_imm, t4_imm[i]);
      check_output($sformatf("fill%0d_rd_valid", i), bus.out_rd_valid, t4_rdv[i]);
      check_output($sformatf("fill%0d_rs1_valid", i), bus.out_rs1_valid, t4_rs1v[i]);
    end
    #1 check_output("robfull_iq_ready", bus.iq_ready, 0);
    apply_stimulus(1'b1, 32'hFFFFFFFF, 32'h300, 1'b1, 1'b1, 1'b0);
    tick();
    commit_valid = 1'b0;
    check_output("commit_out_valid", bus.out_valid, 0);
    #1 check_output("commit_iq_ready", bus.iq_ready, 1);
    tick();
    check_output("ill_valid", bus.out_valid, 1);
    check_output("ill_tag_wrap", bus.out_tag, 0);
    check_output("ill_flag", bus.out_illegal, 1);
    check_output("ill_op", bus.out_op, 0);
    check_output("ill_rs1_valid", bus.out_rs1_valid, 0);
    check_output("ill_rs2_valid", bus.out_rs2_valid, 0);
    check_output("ill_rd_valid", bus.out_rd_valid, 0);

    commit_valid = 1'b1;
    tick();
    apply_stimulus(1'b1, 32'h40B50533, 32'h304, 1'b1, 1'b0, 1'b0);
    tick();
    check_output("sub_op", bus.out_op, 29);
    check_output("sub_illegal", bus.out_illegal, 0);
    check_output("sub_tag", bus.out_tag, 1);
    check_output("sub_rs1", bus.out_rs1, 10);
    check_output("sub_rs2", bus.out_rs2, 11);
    check_output("sub_rd", bus.out_rd, 10);

    apply_stimulus(1'b1, 32'h00000013, 32'h400, 1'b1, 1'b1, 1'b0);
    rdy = 1'b0;
    #1 check_output("frz_iq_ready", bus.iq_ready, 0);
    tick();
    check_output("frz_out_valid", bus.out_valid, 1);
    check_output("frz_tag", bus.out_tag, 1);
    check_output("frz_pc", bus.out_pc, 32'h304);
    rdy = 1'b1;

    rst = 1'b1;
    tick();
    check_output("mrst_out_valid", bus.out_valid, 0);
    check_output("mrst_tag", bus.out_tag, 0);
    check_output("mrst_pc", bus.out_pc, 0);
    check_output("mrst_iq_ready", bus.iq_ready, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
